alu_sequencer: RTL and testbench

- Control-side counterpart of the processor ALU: fetches instructions, decodes them and drives the 5-bit ALU ctrl code, the B-bus source select and register write strobes.
- Latches the ALU zero flag for conditional jumps.
- Sits between instruction/data memory handshake and the datapath. It is the sole driver of ALU ctrl.

---
 rtl/alu_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute control FSM for the processor ALU datapath.
// Every output is a registered Moore output: the next-state decode feeds the
// output registers, so each strobe is visible in the same cycle as its state.
module alu_sequencer #(
  parameter logic [4:0]  NOP_CODE   = 5'b11000,
  parameter logic [4:0]  PASSA_CODE = 5'b00100,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        z,
  input  logic        mem_ack,
  output logic [4:0]  alu_ctrl,
  output logic [3:0]  bus_sel,
  output logic        acc_we,
  output logic [15:0] reg_we,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        mem_re,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        z_flag,
  output logic        halted,
  output logic        err
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_ALU, S_EXEC_MV, S_MEM_RD,
    S_MEM_WR, S_JUMP, S_HALT, S_ABORT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        zf_q, zf_d;

  logic [4:0]  alu_ctrl_q, alu_ctrl_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [15:0] reg_we_q, reg_we_d;
  logic        acc_we_q, acc_we_d;
  logic        ir_load_q, ir_load_d;
  logic        pc_inc_q, pc_inc_d;
  logic        pc_load_q, pc_load_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic        addr_sel_q, addr_sel_d;
  logic        halted_q, halted_d;

  // ir[11:9] only matters to the PC datapath (jump target), not to control.
  logic        unused_ir_bits;
  assign unused_ir_bits = ^ir[11:9];

  // State register, handshake timeout counter, sticky flags and output registers.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      zf_q       <= 1'b0;
      alu_ctrl_q <= NOP_CODE;
      bus_sel_q  <= '0;
      reg_we_q   <= '0;
      acc_we_q   <= 1'b0;
      ir_load_q  <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      zf_q       <= zf_d;
      alu_ctrl_q <= alu_ctrl_d;
      bus_sel_q  <= bus_sel_d;
      reg_we_q   <= reg_we_d;
      acc_we_q   <= acc_we_d;
      ir_load_q  <= ir_load_d;
      pc_inc_q   <= pc_inc_d;
      pc_load_q  <= pc_load_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      addr_sel_q <= addr_sel_d;
      halted_q   <= halted_d;
    end
  end

  // Next state, timeout counting, zero-flag latch and error capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    zf_d    = zf_q;
    case (state_q)
      S_FETCH:    if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        case (ir[15:12])
          4'h0:        state_d = S_FETCH;
          4'h1:        state_d = S_EXEC_ALU;
          4'h2:        state_d = S_EXEC_MV;
          4'h3:        state_d = S_MEM_RD;
          4'h4:        state_d = S_MEM_WR;
          4'h5, 4'h6:  state_d = S_JUMP;
          4'hF:        state_d = S_HALT;
          default: begin
            state_d = S_FETCH;
            err_d   = 1'b1;
          end
        endcase
      end
      S_EXEC_ALU: begin
        if (ir[8:4] != NOP_CODE) zf_d = z;
        state_d = S_FETCH;
      end
      S_EXEC_MV: begin
        zf_d    = z;
        state_d = S_FETCH;
      end
      S_MEM_RD, S_MEM_WR: if (mem_ack) state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ABORT:    state_d = S_HALT;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    // An ack in the final allowed cycle completes normally; only a missing ack aborts.
    if ((state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ack) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_ABORT;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Output decode from the state being entered (plus the MEM_RD->FETCH write pulse).
  always_comb begin
    alu_ctrl_d = NOP_CODE;
    bus_sel_d  = '0;
    reg_we_d   = '0;
    acc_we_d   = 1'b0;
    ir_load_d  = 1'b0;
    pc_inc_d   = 1'b0;
    pc_load_d  = 1'b0;
    mem_re_d   = 1'b0;
    mem_we_d   = 1'b0;
    addr_sel_d = 1'b0;
    halted_d   = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_re_d = 1'b1;
        if (state_q == S_MEM_RD) reg_we_d = 16'h0001 << ir[3:0];
      end
      S_DECODE: begin
        ir_load_d = 1'b1;
        pc_inc_d  = 1'b1;
      end
      S_EXEC_ALU: begin
        alu_ctrl_d = ir[8:4];
        bus_sel_d  = ir[3:0];
        acc_we_d   = (ir[8:4] != NOP_CODE);
      end
      S_EXEC_MV: begin
        alu_ctrl_d = PASSA_CODE;
        reg_we_d   = 16'h0001 << ir[3:0];
      end
      S_MEM_RD: begin
        mem_re_d   = 1'b1;
        addr_sel_d = 1'b1;
      end
      S_MEM_WR: begin
        mem_we_d   = 1'b1;
        addr_sel_d = 1'b1;
        bus_sel_d  = ir[3:0];
      end
      S_JUMP:     pc_load_d = (ir[15:12] == 4'h5) ? 1'b1 : zf_q;
      S_HALT:     halted_d  = 1'b1;
      default: ;
    endcase
  end

  assign alu_ctrl = alu_ctrl_q;
  assign bus_sel  = bus_sel_q;
  assign acc_we   = acc_we_q;
  assign reg_we   = reg_we_q;
  assign ir_load  = ir_load_q;
  assign pc_inc   = pc_inc_q;
  assign pc_load  = pc_load_q;
  assign mem_re   = mem_re_q;
  assign mem_we   = mem_we_q;
  assign addr_sel = addr_sel_q;
  assign z_flag   = zf_q;
  assign halted   = halted_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: instruction tasks push the expected
// strobe snapshots; a negedge monitor pops one whenever a strobe is active.
module tb_alu_sequencer;

  localparam logic [4:0] NOP   = 5'b11000;
  localparam logic [4:0] PASSA = 5'b00100;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = '0;
  logic        z = 1'b0;
  logic        mem_ack = 1'b0;
  logic [4:0]  alu_ctrl;
  logic [3:0]  bus_sel;
  logic        acc_we;
  logic [15:0] reg_we;
  logic        ir_load, pc_inc, pc_load, mem_re, mem_we, addr_sel, z_flag, halted, err;

  int checks = 0;
  int failures = 0;
  logic zf_m = 1'b0;

  typedef struct { string name; logic [29:0] v; } exp_t;
  exp_t sb[$];

  alu_sequencer #(.NOP_CODE(5'b11000), .PASSA_CODE(5'b00100), .TIMEOUT(16)) dut (
    .clk_100(clk_100), .rst(rst), .ir(ir), .z(z), .mem_ack(mem_ack),
    .alu_ctrl(alu_ctrl), .bus_sel(bus_sel), .acc_we(acc_we), .reg_we(reg_we),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .mem_re(mem_re),
    .mem_we(mem_we), .addr_sel(addr_sel), .z_flag(z_flag), .halted(halted), .err(err)
  );

  always #5 clk_100 = ~clk_100;

  function automatic logic [29:0] mk(input logic il, input logic pi, input logic aw,
                                     input logic pl, input logic [4:0] a,
                                     input logic [3:0] b, input logic [15:0] rw,
                                     input logic zf);
    return {il, pi, aw, pl, a, b, rw, zf};
  endfunction

  task automatic push(input string n, input logic [29:0] v);
    exp_t e;
    e.name = n;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: any strobe activity must match the oldest expected snapshot.
  always @(negedge clk_100) begin
    if (!rst && (ir_load || acc_we || reg_we != 16'h0 || pc_load)) begin
      logic [29:0] got;
      exp_t e;
      got = mk(ir_load, pc_inc, acc_we, pc_load, alu_ctrl, bus_sel, reg_we, z_flag);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got=%h required=none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s got=%h required=%h", e.name, got, e.v);
        end
      end
    end
  end

  // kind 0: fetch read, 1: data read, 2: data write
  task automatic wait_req(input int kind);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk_100);
      case (kind)
        0: seen = mem_re && !addr_sel;
        1: seen = mem_re && addr_sel;
        default: seen = mem_we && addr_sel;
      endcase
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_req_%0d got=no_request required=request", kind);
    end
  endtask

  task automatic fetch(input logic [15:0] iv, input logic zv, input int waits);
    wait_req(0);
    repeat (waits) @(negedge clk_100);
    ir = iv;
    z = zv;
    mem_ack = 1'b1;
    push($sformatf("decode_%h", iv), mk(1'b1, 1'b1, 1'b0, 1'b0, NOP, 4'h0, 16'h0, zf_m));
    @(negedge clk_100);
    mem_ack = 1'b0;
  endtask

  task automatic mem_op(input logic wr, input int waits, input logic [3:0] r);
    wait_req(wr ? 2 : 1);
    repeat (waits) @(negedge clk_100);
    if (wr) begin
      chk("stm_bus_sel", 64'(bus_sel), 64'(r));
    end else begin
      push("ldm_reg_we", mk(1'b0, 1'b0, 1'b0, 1'b0, NOP, 4'h0, 16'h0001 << r, zf_m));
    end
    mem_ack = 1'b1;
    @(negedge clk_100);
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_100);
    chk("reset_outputs",
        64'({alu_ctrl, bus_sel, acc_we, reg_we, ir_load, pc_inc, pc_load, mem_re,
             mem_we, addr_sel, z_flag, halted, err}),
        64'({NOP, 30'h0}));
    rst = 1'b0;

    // ADD R3, two wait states, z=1 latched
    fetch(16'h10A3, 1'b1, 2);
    push("exec_add", mk(1'b0, 1'b0, 1'b1, 1'b0, 5'b01010, 4'h3, 16'h0, zf_m));
    zf_m = 1'b1;
    // ALU op equal to NOP code: no acc write, z_flag held although z=0
    fetch(16'h1180, 1'b0, 0);
    @(negedge clk_100);
    chk("nop_op_alu_ctrl", 64'(alu_ctrl), 64'(NOP));
    z = 1'b1;
    // MVACC R5 with z=0, then JMPZ not taken
    fetch(16'h2005, 1'b0, 0);
    push("exec_mv_z0", mk(1'b0, 1'b0, 1'b0, 1'b0, PASSA, 4'h0, 16'h0020, zf_m));
    zf_m = 1'b0;
    fetch(16'h6040, 1'b0, 0);
    // MVACC R5 with z=1, then JMPZ taken
    fetch(16'h2005, 1'b1, 0);
    push("exec_mv_z1", mk(1'b0, 1'b0, 1'b0, 1'b0, PASSA, 4'h0, 16'h0020, zf_m));
    zf_m = 1'b1;
    fetch(16'h6040, 1'b1, 0);
    push("jmpz_taken", mk(1'b0, 1'b0, 1'b0, 1'b1, NOP, 4'h0, 16'h0, zf_m));
    // unconditional JMP
    fetch(16'h5123, 1'b0, 0);
    push("jmp", mk(1'b0, 1'b0, 1'b0, 1'b1, NOP, 4'h0, 16'h0, zf_m));
    // STM R9
    fetch(16'h4009, 1'b0, 0);
    mem_op(1'b1, 1, 4'h9);
    // LDM R2, ack in the 16th cycle: completes normally
    fetch(16'h3002, 1'b0, 0);
    mem_op(1'b0, 15, 4'h2);
    chk("ldm_late_ack_err", 64'(err), 64'h0);
    // illegal class sets sticky err, then normal fetch continues
    fetch(16'h7000, 1'b0, 0);
    @(negedge clk_100);
    chk("illegal_err", 64'(err), 64'h1);
    chk("illegal_next_fetch", 64'({mem_re, addr_sel, halted}), 64'b100);
    fetch(16'h1042, 1'b0, 0);
    push("exec_passa_r2", mk(1'b0, 1'b0, 1'b1, 1'b0, 5'b00100, 4'h2, 16'h0, zf_m));
    zf_m = 1'b0;
    @(negedge clk_100);
    chk("err_sticky", 64'(err), 64'h1);

    // async reset in the middle of a data read
    fetch(16'h3002, 1'b0, 0);
    wait_req(1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rd", 64'({alu_ctrl, mem_re, addr_sel, err}), 64'({NOP, 3'b000}));
    zf_m = 1'b0;
    @(negedge clk_100);
    rst = 1'b0;
    @(negedge clk_100);
    chk("after_rst_fetch", 64'({mem_re, addr_sel, alu_ctrl}), 64'({2'b10, NOP}));

    // LDM R2 with ack withheld 16 cycles: abort then halt
    fetch(16'h3002, 1'b0, 0);
    wait_req(1);
    repeat (15) @(negedge clk_100);
    chk("timeout_cycle16", 64'({mem_re, err}), 64'b10);
    @(negedge clk_100);
    chk("abort_state", 64'({mem_re, mem_we, halted, err}), 64'b0001);
    @(negedge clk_100);
    chk("halt_after_abort", 64'({halted, err, alu_ctrl}), 64'({2'b11, NOP}));

    // HALT instruction: absorbing, no requests regardless of mem_ack
    @(negedge clk_100);
    rst = 1'b1;
    @(negedge clk_100);
    rst = 1'b0;
    zf_m = 1'b0;
    chk("err_cleared", 64'(err), 64'h0);
    fetch(16'hF000, 1'b0, 0);
    @(negedge clk_100);
    chk("halt_entered", 64'({halted, mem_re, alu_ctrl}), 64'({2'b10, NOP}));
    for (int i = 0; i < 8; i++) begin
      mem_ack = i[0];
      @(negedge clk_100);
      chk("halt_hold", 64'({halted, mem_re, mem_we}), 64'b100);
    end
    mem_ack = 1'b0;

    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
